graycode_counter: RTL and testbench
===================================

GRAYCODE_COUNTER -- requirements
Module: graycode

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (legal range 2..16).
REQ-002 SHALL have parameter DOWN, default 0, count direction: 0 = increment, 1 = decrement.
REQ-003 SHALL have parameter INIT, default 0, binary count value loaded on reset (0..2^WIDTH-1).
REQ-004 SHALL have ports in positional order rstn, clk, out, then tc (and bin when enabled).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: reset is synchronous and active-high.
REQ-007 SHALL have port out, output, WIDTH bits: registered Gray-code count.
REQ-008 SHALL have port tc, output, 1 bit: terminal count, high while out holds the last code before wrap.

Function
REQ-009 SHALL keep an internal WIDTH-bit binary counter b and drive out = b XOR (b >> 1), registered so out changes only at rising clk.
REQ-010 SHALL, on every rising clk with rstn low, set b to b+1 (DOWN=0) or b-1 (DOWN=1), modulo 2^WIDTH.
REQ-011 SHALL have no enable input: the count advances on every non-reset clock edge.
REQ-012 SHALL wrap without a stall cycle: up from 2^WIDTH-1 to 0, down from 0 to 2^WIDTH-1.
REQ-013 SHALL change exactly one bit of out on every count step, including at the wrap.
REQ-014 SHALL produce, for WIDTH=4 and DOWN=0 from 0, the sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000.
REQ-015 SHALL drive tc combinationally from the registered state: high when b = 2^WIDTH-1 (DOWN=0) or b = 0 (DOWN=1), otherwise low.
REQ-016 SHALL produce no X on out or tc after the first reset edge.

Reset
REQ-017 SHALL, on any rising clk with rstn high, load b = INIT and out = INIT XOR (INIT >> 1), regardless of the current count.
REQ-018 SHALL let reset take priority over counting, including a reset asserted mid-sequence or on the wrap edge.
REQ-019 SHALL resume counting from the reset value on the first rising clk with rstn low; the first step gives gray(INIT+1) (up) or gray(INIT-1) (down).
REQ-020 SHALL update tc in the same cycle as the reset value appears on out.

Configuration
REQ-021 SHALL use macro GRAYCODE_BIN_OUT_EN: when defined, add output port bin, WIDTH bits, placed after tc, carrying the registered binary count b.
REQ-022 SHALL, with GRAYCODE_BIN_OUT_EN undefined, omit port bin entirely and leave out and tc behaviour unchanged.

Verification
REQ-023 SHALL cover: defaults, rstn high for 1 edge -> out=0000, tc=0.
REQ-024 SHALL cover: release reset, 17 edges -> out follows REQ-014, tc=1 only while out=1000, the 16th edge gives 0000, the 17th gives 0001.
REQ-025 SHALL cover: reset asserted while out=0110 -> out=0000 on that edge, counting restarts at 0001.
REQ-026 SHALL cover: DOWN=1, WIDTH=4 after reset -> out 0000, 1000, 1001, ...; tc=1 while out=0000.
REQ-027 SHALL cover: WIDTH=3, INIT=5 -> reset gives out=111, then 101, 100, 000.
REQ-028 SHALL cover: GRAYCODE_BIN_OUT_EN defined -> bin=k and out=k XOR (k>>1) after k edges, with a single-bit change checked on every step.

Source files
------------

// File: rtl/graycode_counter.sv
`default_nettype none
// ============================================================================
// Module   : graycode_counter
// Purpose  : Free-running Gray-code counter. An internal WIDTH-bit binary
//            count b advances by one (or retreats by one when DOWN=1) on every
//            rising clk edge while rstn is low. The Gray image of the next
//            count is registered directly, so out only changes at the edge.
//            tc flags the last code before the wrap.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH : counter width in bits (2..16)
//   DOWN  : 0 = increment, 1 = decrement
//   INIT  : binary count loaded on reset (0..2^WIDTH-1)
// Ports
//   rstn  : in   synchronous reset, ACTIVE-HIGH despite the name
//   clk   : in   clock, rising edge
//   out   : out  registered Gray-code count
//   tc    : out  terminal count (b = 2^WIDTH-1 up, b = 0 down)
//   bin   : out  registered binary count (only with GRAYCODE_BIN_OUT_EN)
// Configuration macro
//   GRAYCODE_BIN_OUT_EN : when defined, adds the bin output port
// ============================================================================
module graycode_counter #(
    parameter int WIDTH = 4,
    parameter bit DOWN  = 1'b0,
    parameter int INIT  = 0
) (
    input  logic             rstn,
    input  logic             clk,
    output logic [WIDTH-1:0] out,
    output logic             tc
`ifdef GRAYCODE_BIN_OUT_EN
    ,
    output logic [WIDTH-1:0] bin
`endif
);

    localparam logic [WIDTH-1:0] C_ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] C_INIT_BIN  = INIT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] C_INIT_GRAY = C_INIT_BIN ^ (C_INIT_BIN >> 1);
    // Last binary value before the wrap, depending on direction.
    localparam logic [WIDTH-1:0] C_TERM      = DOWN ? {WIDTH{1'b0}} : {WIDTH{1'b1}};

    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;

    // Next binary count wraps naturally through modulo-2^WIDTH arithmetic,
    // so there is no stall cycle at either end of the range.
    generate
        if (DOWN) begin : g_down
            always_comb begin
                b_d = b_q - C_ONE;
            end
        end else begin : g_up
            always_comb begin
                b_d = b_q + C_ONE;
            end
        end
    endgenerate

    // Gray image of the next count; registering it (rather than decoding b_q
    // after the flop) keeps out glitch-free.
    always_comb begin
        out_d = b_d ^ (b_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            b_q   <= C_INIT_BIN;
            out_q <= C_INIT_GRAY;
        end else begin
            b_q   <= b_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;
    assign tc  = (b_q == C_TERM);

`ifdef GRAYCODE_BIN_OUT_EN
    assign bin = b_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_graycode_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_graycode_counter
// Purpose  : Directed self-checking bench for graycode_counter. Three
//            instances share clk and rstn: defaults (up, WIDTH=4), DOWN=1,
//            and WIDTH=3 with INIT=5. Expected codes come from hand-written
//            Gray tables indexed by the expected binary count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_graycode_counter;

    logic clk = 1'b0;
    logic rstn;

    logic [3:0] up_out;
    logic       up_tc;
    logic [3:0] dn_out;
    logic       dn_tc;
    logic [2:0] w3_out;
    logic       w3_tc;
`ifdef GRAYCODE_BIN_OUT_EN
    logic [3:0] up_bin;
    logic [3:0] dn_bin;
    logic [2:0] w3_bin;
`endif

    always #5 clk = ~clk;

    graycode_counter u_up (
        .rstn (rstn),
        .clk  (clk),
        .out  (up_out),
        .tc   (up_tc)
`ifdef GRAYCODE_BIN_OUT_EN
        ,
        .bin  (up_bin)
`endif
    );

    graycode_counter #(.WIDTH(4), .DOWN(1'b1), .INIT(0)) u_dn (
        .rstn (rstn),
        .clk  (clk),
        .out  (dn_out),
        .tc   (dn_tc)
`ifdef GRAYCODE_BIN_OUT_EN
        ,
        .bin  (dn_bin)
`endif
    );

    graycode_counter #(.WIDTH(3), .DOWN(1'b0), .INIT(5)) u_w3 (
        .rstn (rstn),
        .clk  (clk),
        .out  (w3_out),
        .tc   (w3_tc)
`ifdef GRAYCODE_BIN_OUT_EN
        ,
        .bin  (w3_bin)
`endif
    );

    // Hand-written Gray tables: entry k is gray(k).
    logic [3:0] G4 [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                            4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110,
                            4'b1010, 4'b1011, 4'b1001, 4'b1000};
    logic [2:0] G3 [8]  = '{3'b000, 3'b001, 3'b011, 3'b010,
                            3'b110, 3'b111, 3'b101, 3'b100};

    int n_vec  = 0;
    int n_fail = 0;

    // Expected binary counts of the three instances.
    int k_up = 0;
    int k_dn = 0;
    int k_w3 = 5;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string ph);
        check_eq($sformatf("%s up_out b=%0d", ph, k_up), {28'd0, up_out}, {28'd0, G4[k_up]});
        check_eq($sformatf("%s up_tc b=%0d",  ph, k_up), {31'd0, up_tc},  {31'd0, (k_up == 15)});
        check_eq($sformatf("%s dn_out b=%0d", ph, k_dn), {28'd0, dn_out}, {28'd0, G4[k_dn]});
        check_eq($sformatf("%s dn_tc b=%0d",  ph, k_dn), {31'd0, dn_tc},  {31'd0, (k_dn == 0)});
        check_eq($sformatf("%s w3_out b=%0d", ph, k_w3), {29'd0, w3_out}, {29'd0, G3[k_w3]});
        check_eq($sformatf("%s w3_tc b=%0d",  ph, k_w3), {31'd0, w3_tc},  {31'd0, (k_w3 == 7)});
`ifdef GRAYCODE_BIN_OUT_EN
        check_eq($sformatf("%s up_bin", ph), {28'd0, up_bin}, k_up);
        check_eq($sformatf("%s dn_bin", ph), {28'd0, dn_bin}, k_dn);
        check_eq($sformatf("%s w3_bin", ph), {29'd0, w3_bin}, k_w3);
`endif
    endtask

    task automatic step_count(input string ph);
        logic [3:0] p_up;
        logic [3:0] p_dn;
        logic [2:0] p_w3;
        p_up = up_out;
        p_dn = dn_out;
        p_w3 = w3_out;
        tick();
        k_up = (k_up + 1) % 16;
        k_dn = (k_dn + 15) % 16;
        k_w3 = (k_w3 + 1) % 8;
        check_all(ph);
        check_eq({ph, " up 1-bit step"}, $countones(p_up ^ up_out), 1);
        check_eq({ph, " dn 1-bit step"}, $countones(p_dn ^ dn_out), 1);
        check_eq({ph, " w3 1-bit step"}, $countones(p_w3 ^ w3_out), 1);
    endtask

    task automatic step_reset(input string ph);
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
        k_up = 0;
        k_dn = 0;
        k_w3 = 5;
        check_all(ph);
    endtask

    initial begin
        rstn = 1'b1;

        // Reset state: up 0000/tc=0, down 0000/tc=1, W3 INIT=5 -> 111.
        step_reset("reset");
        check_eq("w3 reset code", {29'd0, w3_out}, 32'h7);

        // Full up cycle plus one: wraps to 0000 on edge 16, 0001 on edge 17.
        for (int i = 1; i <= 17; i++) begin
            step_count($sformatf("run%0d", i));
        end
        check_eq("up after 17 edges", {28'd0, up_out}, 32'h1);

        // Advance to 0110 and reset mid-sequence.
        for (int i = 0; i < 3; i++) begin
            step_count("to0110");
        end
        check_eq("up before mid reset", {28'd0, up_out}, 32'h6);
        step_reset("midreset");
        step_count("restart");
        check_eq("up restart code", {28'd0, up_out}, 32'h1);

        // Reset asserted on the wrap edge (out=1000, tc=1).
        for (int i = 0; i < 14; i++) begin
            step_count("towrap");
        end
        check_eq("up tc before wrap reset", {31'd0, up_tc}, 32'h1);
        step_reset("wrapreset");
        step_count("post");
        step_count("post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
